// File: rtl/clint_if.sv
// Bus bundle between the pipeline and the core-local interrupt sequencer.
// The slave modport is the sequencer's view; master is the core/CSR side.
interface clint_if #(
   parameter int INT_W = 8
);
   logic [INT_W-1:0] int_flag;
   logic [31:0]      inst;
   logic [31:0]      inst_addr;
   logic             jump_flag;
   logic [31:0]      jump_addr;
   logic             hold_flag_ex;
   logic [31:0]      csr_mtvec;
   logic [31:0]      csr_mepc;
   logic [31:0]      csr_mstatus;
   logic             csr_we;
   logic [11:0]      csr_waddr;
   logic [31:0]      csr_wdata;
   logic             clear_flag_int;
   logic             int_assert;
   logic [31:0]      int_addr;

   modport slave (
      input  int_flag, inst, inst_addr, jump_flag, jump_addr, hold_flag_ex,
      input  csr_mtvec, csr_mepc, csr_mstatus,
      output csr_we, csr_waddr, csr_wdata, clear_flag_int, int_assert, int_addr
   );

   modport master (
      output int_flag, inst, inst_addr, jump_flag, jump_addr, hold_flag_ex,
      output csr_mtvec, csr_mepc, csr_mstatus,
      input  csr_we, csr_waddr, csr_wdata, clear_flag_int, int_assert, int_addr
   );
endinterface

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: on ecall/ebreak/interrupt it writes
// mepc, mstatus, mcause and redirects to mtvec; on mret it restores mstatus and returns to mepc.
module clint #(
   parameter int          INT_W       = 8,
   parameter logic [11:0] CSR_MSTATUS = 12'h300,
   parameter logic [11:0] CSR_MEPC    = 12'h341,
   parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
   input logic    clk,
   input logic    rst,
   clint_if.slave bus
);

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;
   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;
   localparam logic [31:0] CAUSE_ASYNC  = 32'h8000_000B;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEPC,
      S_MSTATUS,
      S_MCAUSE,
      S_ASSERT,
      S_MRET
   } state_t;

   state_t      state_q;
   logic        csr_we_q;
   logic [11:0] csr_waddr_q;
   logic [31:0] csr_wdata_q;
   logic        int_assert_q;
   logic [31:0] int_addr_q;
   logic [31:0] cause_q;

   logic [INT_W-1:0] int_flag_w;
   logic        is_ecall;
   logic        is_ebreak;
   logic        is_mret;
   logic        idle;
   logic        take_sync;
   logic        take_async;
   logic        take_mret;
   logic [31:0] cause_d;
   logic [31:0] ret_addr_d;
   logic [31:0] mstatus_trap_d;
   logic [31:0] mstatus_mret_d;

   assign int_flag_w = bus.int_flag;
   assign is_ecall   = (bus.inst == INST_ECALL);
   assign is_ebreak  = (bus.inst == INST_EBREAK);
   assign is_mret    = (bus.inst == INST_MRET);
   assign idle       = (state_q == S_IDLE);

   // Priority: synchronous exception, then enabled interrupt, then mret.
   assign take_sync  = idle && (is_ecall || is_ebreak);
   assign take_async = idle && !(is_ecall || is_ebreak) && (|int_flag_w)
                       && bus.csr_mstatus[3] && !bus.hold_flag_ex;
   assign take_mret  = idle && !(is_ecall || is_ebreak) && !take_async && is_mret;

   always_comb begin
      cause_d    = is_ecall ? CAUSE_ECALL : (is_ebreak ? CAUSE_EBREAK : CAUSE_ASYNC);
      ret_addr_d = (take_async && bus.jump_flag) ? bus.jump_addr : bus.inst_addr;

      mstatus_trap_d    = bus.csr_mstatus;
      mstatus_trap_d[7] = bus.csr_mstatus[3];
      mstatus_trap_d[3] = 1'b0;

      mstatus_mret_d    = bus.csr_mstatus;
      mstatus_mret_d[3] = bus.csr_mstatus[7];
      mstatus_mret_d[7] = 1'b1;
   end

   // Each output word is computed on the edge that enters the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         csr_we_q     <= 1'b0;
         csr_waddr_q  <= '0;
         csr_wdata_q  <= '0;
         int_assert_q <= 1'b0;
         int_addr_q   <= '0;
         cause_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               csr_we_q     <= 1'b0;
               csr_waddr_q  <= '0;
               csr_wdata_q  <= '0;
               int_assert_q <= 1'b0;
               int_addr_q   <= '0;
               if (take_sync || take_async) begin
                  state_q     <= S_MEPC;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CSR_MEPC;
                  csr_wdata_q <= ret_addr_d;
                  cause_q     <= cause_d;
               end else if (take_mret) begin
                  state_q     <= S_MRET;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CSR_MSTATUS;
                  csr_wdata_q <= mstatus_mret_d;
               end
            end
            S_MEPC: begin
               state_q     <= S_MSTATUS;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CSR_MSTATUS;
               csr_wdata_q <= mstatus_trap_d;
            end
            S_MSTATUS: begin
               state_q     <= S_MCAUSE;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CSR_MCAUSE;
               csr_wdata_q <= cause_q;
            end
            S_MCAUSE, S_MRET: begin
               state_q      <= S_ASSERT;
               csr_we_q     <= 1'b0;
               csr_waddr_q  <= '0;
               csr_wdata_q  <= '0;
               int_assert_q <= 1'b1;
               int_addr_q   <= (state_q == S_MRET) ? bus.csr_mepc : bus.csr_mtvec;
            end
            S_ASSERT: begin
               state_q      <= S_IDLE;
               csr_we_q     <= 1'b0;
               csr_waddr_q  <= '0;
               csr_wdata_q  <= '0;
               int_assert_q <= 1'b0;
               int_addr_q   <= '0;
            end
            default: begin
               state_q      <= S_IDLE;
               csr_we_q     <= 1'b0;
               csr_waddr_q  <= '0;
               csr_wdata_q  <= '0;
               int_assert_q <= 1'b0;
               int_addr_q   <= '0;
            end
         endcase
      end
   end

   // The flush request must reach ctrl in the trigger cycle itself, hence the combinational term.
   assign bus.clear_flag_int = !idle || take_sync || take_async || take_mret;
   assign bus.csr_we         = csr_we_q;
   assign bus.csr_waddr      = csr_waddr_q;
   assign bus.csr_wdata      = csr_wdata_q;
   assign bus.int_assert     = int_assert_q;
   assign bus.int_addr       = int_addr_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: a transaction-level trap/mret model predicts the
// per-cycle CSR write stream and redirect, and a tiny CSR file feeds mstatus/mepc back.
module tb_clint;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct packed {
      logic        we;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic        ia;
      logic [31:0] iaddr;
   } out_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   clint_if #(.INT_W(8)) bus ();

   clint #(
      .INT_W(8),
      .CSR_MSTATUS(12'h300),
      .CSR_MEPC(12'h341),
      .CSR_MCAUSE(12'h342)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: remaining busy cycles, expected output records, pending CSR write.
   int          busy;
   out_t        expq[$];
   logic        pend;
   logic [11:0] pend_addr;
   logic [31:0] pend_data;

   function automatic out_t mk(logic we, logic [11:0] a, logic [31:0] d, logic ia, logic [31:0] ia_addr);
      out_t r;
      r.we = we; r.waddr = a; r.wdata = d; r.ia = ia; r.iaddr = ia_addr;
      return r;
   endfunction

   // One clock: predict clear_flag_int at negedge, then the registered outputs just after posedge.
   task automatic advance(output logic ec, output logic gc, output out_t eo, output out_t go);
      logic        is_sync, is_async, is_mret;
      logic [31:0] ret, cause, ms;
      @(negedge clk);
      is_sync  = (busy == 0) && (bus.inst == ECALL || bus.inst == EBREAK);
      is_async = (busy == 0) && !is_sync && (bus.int_flag != 0) && bus.csr_mstatus[3] && !bus.hold_flag_ex;
      is_mret  = (busy == 0) && !is_sync && !is_async && (bus.inst == MRET);
      ec = (busy > 0) || is_sync || is_async || is_mret;
      gc = bus.clear_flag_int;
      if (busy > 0) busy--;
      if (!rst && (is_sync || is_async)) begin
         ret   = (is_async && bus.jump_flag) ? bus.jump_addr : bus.inst_addr;
         cause = (bus.inst == ECALL) ? 32'd11 : (is_sync ? 32'd3 : 32'h8000_000B);
         ms    = bus.csr_mstatus;
         ms[7] = bus.csr_mstatus[3];
         ms[3] = 1'b0;
         expq.push_back(mk(1'b1, 12'h341, ret, 1'b0, 32'h0));
         expq.push_back(mk(1'b1, 12'h300, ms, 1'b0, 32'h0));
         expq.push_back(mk(1'b1, 12'h342, cause, 1'b0, 32'h0));
         expq.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, bus.csr_mtvec));
         busy = 4;
      end else if (!rst && is_mret) begin
         ms    = bus.csr_mstatus;
         ms[3] = bus.csr_mstatus[7];
         ms[7] = 1'b1;
         expq.push_back(mk(1'b1, 12'h300, ms, 1'b0, 32'h0));
         expq.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, bus.csr_mepc));
         busy = 2;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         expq.delete();
         busy = 0;
         pend = 1'b0;
      end
      if (pend) begin
         if (pend_addr == 12'h300) bus.csr_mstatus = pend_data;
         if (pend_addr == 12'h341) bus.csr_mepc = pend_data;
         pend = 1'b0;
      end
      eo = (expq.size() > 0) ? expq.pop_front() : '0;
      go = mk(bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.int_assert, bus.int_addr);
      if (eo.we) begin
         pend      = 1'b1;
         pend_addr = eo.waddr;
         pend_data = eo.wdata;
      end
   endtask

   task automatic set_idle_inputs();
      bus.int_flag     = '0;
      bus.inst         = NOP;
      bus.inst_addr    = 32'h0;
      bus.jump_flag    = 1'b0;
      bus.jump_addr    = 32'h0;
      bus.hold_flag_ex = 1'b0;
   endtask

   task automatic test_reset();
      logic ec, gc;
      out_t eo, go;
      rst = 1'b1;
      set_idle_inputs();
      bus.csr_mtvec = 32'h80;
      bus.csr_mepc = 32'h0;
      bus.csr_mstatus = 32'h0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) rst = 1'b0;
         advance(ec, gc, eo, go);
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL reset_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== '0) begin errors++; $display("FAIL reset_out cyc%0d got=%h exp=0", i, go); end
      end
   endtask

   task automatic test_ecall();
      logic ec, gc;
      out_t eo, go;
      bus.csr_mtvec = 32'h80;
      bus.csr_mstatus = 32'h8;
      bus.inst = ECALL;
      bus.inst_addr = 32'h100;
      for (int i = 0; i < 7; i++) begin
         advance(ec, gc, eo, go);
         if (i == 0) bus.inst = NOP;
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL ecall_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL ecall_out cyc%0d got=%h exp=%h", i, go, eo); end
         if (i == 0) begin
            checks++;
            if (go.wdata !== 32'h100) begin errors++; $display("FAIL ecall_mepc got=%h exp=00000100", go.wdata); end
         end
         if (i == 3) begin
            checks++;
            if (go.ia !== 1'b1 || go.iaddr !== 32'h80) begin
               errors++; $display("FAIL ecall_redirect got=%b/%h exp=1/00000080", go.ia, go.iaddr);
            end
         end
      end
   endtask

   task automatic test_ebreak();
      logic ec, gc;
      out_t eo, go;
      bus.csr_mtvec = $urandom & 32'hFFFF_FFFC;
      bus.csr_mstatus = $urandom;
      bus.inst = EBREAK;
      bus.inst_addr = $urandom & 32'hFFFF_FFFC;
      bus.hold_flag_ex = 1'b1;
      for (int i = 0; i < 6; i++) begin
         advance(ec, gc, eo, go);
         if (i == 0) begin bus.inst = NOP; bus.hold_flag_ex = 1'b0; end
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL ebreak_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL ebreak_out cyc%0d got=%h exp=%h", i, go, eo); end
      end
   endtask

   task automatic test_async();
      logic ec, gc;
      out_t eo, go;
      bus.csr_mtvec = 32'h400;
      bus.csr_mstatus = 32'h8;
      bus.int_flag = 8'h01;
      bus.jump_flag = 1'b1;
      bus.jump_addr = 32'h200;
      bus.inst_addr = 32'h1F0;
      for (int i = 0; i < 8; i++) begin
         advance(ec, gc, eo, go);
         if (i == 0) bus.jump_flag = 1'b0;
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL async_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL async_out cyc%0d got=%h exp=%h", i, go, eo); end
         if (i == 0 || i == 2) begin
            checks++;
            if (go.wdata !== ((i == 0) ? 32'h200 : 32'h8000_000B)) begin
               errors++; $display("FAIL async_word cyc%0d got=%h", i, go.wdata);
            end
         end
      end
      bus.csr_mstatus = 32'h0;
      bus.int_flag = 8'($urandom_range(1, 255));
      for (int i = 0; i < 4; i++) begin
         advance(ec, gc, eo, go);
         checks++;
         if (gc !== 1'b0) begin errors++; $display("FAIL async_masked_clear cyc%0d got=%b exp=0", i, gc); end
         checks++;
         if (go !== '0) begin errors++; $display("FAIL async_masked_out cyc%0d got=%h exp=0", i, go); end
      end
      bus.int_flag = '0;
   endtask

   task automatic test_mret();
      logic ec, gc;
      out_t eo, go;
      bus.csr_mepc = 32'h104;
      bus.csr_mstatus = 32'h80;
      bus.inst = MRET;
      for (int i = 0; i < 4; i++) begin
         advance(ec, gc, eo, go);
         if (i == 0) bus.inst = NOP;
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL mret_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL mret_out cyc%0d got=%h exp=%h", i, go, eo); end
         if (i == 0) begin
            checks++;
            if (go.wdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h exp=00000088", go.wdata); end
         end
         if (i == 1) begin
            checks++;
            if (go.iaddr !== 32'h104) begin errors++; $display("FAIL mret_addr got=%h exp=00000104", go.iaddr); end
         end
      end
   endtask

   task automatic test_hold();
      logic ec, gc;
      out_t eo, go;
      bus.csr_mstatus = 32'h8;
      bus.int_flag = 8'h01;
      bus.hold_flag_ex = 1'b1;
      bus.inst_addr = 32'h300;
      for (int i = 0; i < 11; i++) begin
         advance(ec, gc, eo, go);
         if (i == 4) bus.hold_flag_ex = 1'b0;
         if (i == 5) bus.int_flag = '0;
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL hold_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL hold_out cyc%0d got=%h exp=%h", i, go, eo); end
      end
   endtask

   task automatic test_sync_async();
      logic ec, gc;
      out_t eo, go;
      logic [31:0] causes[$];
      bus.csr_mstatus = 32'h8;
      bus.csr_mtvec = 32'h80;
      bus.inst = ECALL;
      bus.inst_addr = 32'h500;
      bus.int_flag = 8'h10;
      for (int i = 0; i < 16; i++) begin
         advance(ec, gc, eo, go);
         if (i == 0 || i == 8) bus.inst = NOP;
         if (i == 7) begin bus.inst = MRET; end
         if (go.we === 1'b1 && go.waddr === 12'h342) causes.push_back(go.wdata);
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL sa_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL sa_out cyc%0d got=%h exp=%h", i, go, eo); end
      end
      bus.int_flag = '0;
      checks++;
      if (causes.size() !== 2) begin
         errors++; $display("FAIL sa_cause_count got=%0d exp=2", causes.size());
      end else begin
         checks++;
         if (causes[0] !== 32'd11 || causes[1] !== 32'h8000_000B) begin
            errors++; $display("FAIL sa_cause_order got=%h,%h exp=0000000b,8000000b", causes[0], causes[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic ec, gc;
      out_t eo, go;
      bus.csr_mstatus = 32'h8;
      bus.inst = ECALL;
      bus.inst_addr = 32'h600;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) rst = 1'b1;
         if (i == 4) rst = 1'b0;
         advance(ec, gc, eo, go);
         if (i == 0) bus.inst = NOP;
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL rstmid_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL rstmid_out cyc%0d got=%h exp=%h", i, go, eo); end
         if (i >= 3) begin
            checks++;
            if (go !== '0) begin errors++; $display("FAIL rstmid_zero cyc%0d got=%h exp=0", i, go); end
         end
      end
   endtask

   task automatic test_random();
      logic ec, gc;
      out_t eo, go;
      int   sel;
      bus.csr_mtvec = $urandom & 32'hFFFF_FFFC;
      bus.csr_mstatus = 32'h8;
      for (int i = 0; i < 400; i++) begin
         advance(ec, gc, eo, go);
         checks++;
         if (gc !== ec) begin errors++; $display("FAIL rand_clear cyc%0d got=%b exp=%b", i, gc, ec); end
         checks++;
         if (go !== eo) begin errors++; $display("FAIL rand_out cyc%0d got=%h exp=%h", i, go, eo); end
         sel = $urandom_range(0, 9);
         bus.inst = (sel == 0) ? ECALL : (sel == 1) ? EBREAK : (sel == 2) ? MRET : ($urandom & 32'hFFFF_FFFE);
         bus.int_flag = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
         bus.hold_flag_ex = ($urandom_range(0, 3) == 0);
         bus.jump_flag = $urandom_range(0, 1);
         bus.jump_addr = $urandom;
         bus.inst_addr = $urandom;
         if (busy == 0 && !pend && $urandom_range(0, 7) == 0) bus.csr_mstatus[3] = 1'b1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      busy = 0;
      pend = 1'b0;
      pend_addr = '0;
      pend_data = '0;
      rst = 1'b1;
      set_idle_inputs();
      bus.csr_mtvec = '0;
      bus.csr_mepc = '0;
      bus.csr_mstatus = '0;
      test_reset();
      test_ecall();
      test_ebreak();
      test_async();
      test_mret();
      test_hold();
      test_sync_async();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
